// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one WIDTH-bit adder reused over WIDTH cycles, start/busy/done handshake.
// Define MULT_SIGNED_EN to compile in two's-complement support selected per operation by sgn.
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   p_q, p_d;

   logic                 accept;
   logic                 last_iter;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_shift;
   logic [2*WIDTH-1:0]   result;
   logic [WIDTH-1:0]     a_mag, b_mag;

`ifdef MULT_SIGNED_EN
   logic                 neg_q, neg_d;

   // Signed operands become magnitudes at capture; the sign is reapplied once at the end.
   always_comb begin
      a_mag  = (sgn && a[WIDTH-1]) ? WIDTH'(-a) : a;
      b_mag  = (sgn && b[WIDTH-1]) ? WIDTH'(-b) : b;
      neg_d  = accept ? (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) : neg_q;
      result = neg_q ? (2*WIDTH)'(-acc_shift) : acc_shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) neg_q <= 1'b0;
      else     neg_q <= neg_d;
   end
`else
   wire unused_sgn = sgn;

   always_comb begin
      a_mag  = a;
      b_mag  = b;
      result = acc_shift;
   end
`endif

   // Multiplier lives in the low half of the accumulator so its LSB is always acc_q[0].
   always_comb begin
      sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      acc_shift = {sum, acc_q[WIDTH-1:1]};
      accept    = start && (state_q != RUN);
      last_iter = (cnt_q == CW'(WIDTH-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_iter) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      p    = p_q;
   end

   always_comb begin
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      if (accept) begin
         mcand_d = a_mag;
         acc_d   = {{WIDTH{1'b0}}, b_mag};
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         acc_d = acc_shift;
         cnt_d = cnt_q + CW'(1);
         if (last_iter) p_d = result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a WIDTH=4 instance for handshake/reset cases and a WIDTH=8 instance.
// Signed cases are exercised only when MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, sgn = 1'b0;
   logic [3:0]  a = '0, b = '0;
   logic        busy, done;
   logic [7:0]  p;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] p8;

   int n_cmp = 0;
   int n_bad = 0;

   seq_multiplier #(.WIDTH(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
      .busy(busy), .done(done), .p(p)
   );

   seq_multiplier #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sgn(1'b0), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] ai, input logic [3:0] bi, input logic si, input logic st);
      a     = ai;
      b     = bi;
      sgn   = si;
      start = st;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Single start pulse, bounded wait for done, then latency, busy length and product checked.
   task automatic runOp(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                        input logic [7:0] exp_p, input string tag);
      int lat;
      int busy_cnt;
      applyStimulus(ai, bi, si, 1'b1);
      step();
      applyStimulus(ai, bi, si, 1'b0);
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         step();
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, 5);
      checkOutput({tag, "_busycycles"}, busy_cnt, 4);
      checkOutput({tag, "_p"}, p, exp_p);
      checkOutput({tag, "_busy_in_done"}, busy, 1'b0);
      step();
      checkOutput({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int done_cnt;

      $display("[TB] start");
      #2;
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_p", p, 8'h00);
      step();
      rst = 1'b0;
      step();
      checkOutput("idle_busy", busy, 1'b0);

      // 15*15 with exact handshake timing
      runOp(4'd15, 4'd15, 1'b0, 8'hE1, "max15x15");

      // Back-to-back: start held through DONE
      applyStimulus(4'd0, 4'd9, 1'b0, 1'b1);
      step();
      checkOutput("b2b_busy_first", busy, 1'b1);
      checkOutput("b2b_p_held", p, 8'hE1);
      applyStimulus(4'd7, 4'd1, 1'b0, 1'b1);
      step(); step(); step();
      checkOutput("b2b_no_early_done", done, 1'b0);
      step();
      checkOutput("b2b_done1", done, 1'b1);
      checkOutput("b2b_p_zero", p, 8'h00);
      step();
      applyStimulus(4'd7, 4'd1, 1'b0, 1'b0);
      checkOutput("b2b_rerun_busy", busy, 1'b1);
      checkOutput("b2b_p_held_zero", p, 8'h00);
      step(); step(); step();
      checkOutput("b2b_second_not_yet", done, 1'b0);
      step();
      checkOutput("b2b_done2", done, 1'b1);
      checkOutput("b2b_p_seven", p, 8'h07);
      step();

      // Start during RUN is ignored and not queued
      applyStimulus(4'd3, 4'd5, 1'b0, 1'b1);
      step();
      applyStimulus(4'd3, 4'd5, 1'b0, 1'b0);
      step();
      applyStimulus(4'd2, 4'd2, 1'b0, 1'b1);
      step();
      applyStimulus(4'd2, 4'd2, 1'b0, 1'b0);
      step();
      checkOutput("ign_not_yet", done, 1'b0);
      step();
      checkOutput("ign_done", done, 1'b1);
      checkOutput("ign_p", p, 8'd15);
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done || busy) done_cnt++;
      end
      checkOutput("ign_no_queue", done_cnt, 0);

      // Reset mid-RUN aborts
      applyStimulus(4'd12, 4'd11, 1'b0, 1'b1);
      step();
      applyStimulus(4'd12, 4'd11, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      #1;
      checkOutput("rst_p", p, 8'h00);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      step();
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) done_cnt++;
      end
      checkOutput("rst_no_done", done_cnt, 0);
      runOp(4'd12, 4'd11, 1'b0, 8'd132, "post_rst");

`ifdef MULT_SIGNED_EN
      runOp(4'b1000, 4'b1000, 1'b1, 8'h40, "s_m8xm8");
      runOp(4'b1101, 4'd5, 1'b1, 8'hF1, "s_m3x5");
      runOp(4'b1101, 4'd5, 1'b0, 8'h41, "u_13x5");
`else
      runOp(4'b1101, 4'd5, 1'b1, 8'h41, "sgn_ignored");
`endif

      // WIDTH=8 instance
      a8 = 8'd255;
      b8 = 8'd255;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done8 && lat < 60) begin
         if (busy8) busy_cnt++;
         step();
         lat++;
      end
      checkOutput("w8_latency", lat, 9);
      checkOutput("w8_busycycles", busy_cnt, 8);
      checkOutput("w8_p", p8, 16'hFE01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
